// File: rtl/vp_glyph_expander.sv
// Glyph row expander: turns one bitmap row plus colour/attribute bits into packed
// colour pixels, with a blink timer and a one-entry skid buffer on the output.
module vp_glyph_expander #(
  parameter int WIDTH        = 16,
  parameter int COLOR_BITS   = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_tick,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            bitmap,
  input  logic [COLOR_BITS-1:0]       foreground,
  input  logic [COLOR_BITS-1:0]       background,
  input  logic                        invert,
  input  logic                        underline,
  input  logic                        blink,
  input  logic                        dw_enable,
  input  logic                        dw_part,
  output logic [WIDTH*COLOR_BITS-1:0] pixels,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        blink_phase
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0]               blink_cnt;
  logic [WIDTH-1:0]            dw_bits;
  logic [WIDTH-1:0]            b_sel;
  logic [WIDTH-1:0]            b_final;
  logic [COLOR_BITS-1:0]       on_color;
  logic [COLOR_BITS-1:0]       off_color;
  logic [WIDTH*COLOR_BITS-1:0] pix_next;
  logic [WIDTH*COLOR_BITS-1:0] out_data;
  logic [WIDTH*COLOR_BITS-1:0] skid_data;
  logic                        skid_full;
  logic                        accept;
  logic                        xfer;

  // Blink timer: phase flips every BLINK_FRAMES frame ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Bit transform: double-width select, underline, blink (wins over underline).
  always_comb begin
    b_sel     = dw_enable ? dw_bits : bitmap;
    b_final   = underline ? '1 : b_sel;
    if (blink && blink_phase) b_final = '0;
    on_color  = invert ? background : foreground;
    off_color = invert ? foreground : background;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pix
    assign dw_bits[g] = dw_part ? bitmap[WIDTH/2 + g/2] : bitmap[g/2];
    assign pix_next[(WIDTH-1-g)*COLOR_BITS +: COLOR_BITS] = b_final[g] ? on_color : off_color;
  end

  // Handshake: a word moves when valid and ready are both high at a rising edge;
  // valid never drops and data never changes while a word waits for ready.
  // in_ready is the registered "skid empty" flag, so it never depends on out_ready.
  assign in_ready = ~skid_full;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign pixels   = out_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_data <= '0;
      skid_full <= 1'b0;
    end else if (skid_full) begin
      if (xfer) begin
        out_data  <= skid_data;
        skid_full <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || xfer) begin
        out_data  <= pix_next;
        out_valid <= 1'b1;
      end else begin
        skid_data <= pix_next;
        skid_full <= 1'b1;
      end
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vp_glyph_expander.sv
// Directed self-checking bench for vp_glyph_expander (16 px, 4-bit colour, blink period 2).
module tb_vp_glyph_expander;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bitmap;
  logic [3:0]  foreground;
  logic [3:0]  background;
  logic        invert;
  logic        underline;
  logic        blink;
  logic        dw_enable;
  logic        dw_part;
  logic [63:0] pixels;
  logic        out_valid;
  logic        out_ready;
  logic        blink_phase;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  vp_glyph_expander #(.WIDTH(16), .COLOR_BITS(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .in_valid(in_valid), .in_ready(in_ready), .bitmap(bitmap),
    .foreground(foreground), .background(background), .invert(invert),
    .underline(underline), .blink(blink), .dw_enable(dw_enable), .dw_part(dw_part),
    .pixels(pixels), .out_valid(out_valid), .out_ready(out_ready), .blink_phase(blink_phase)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic drive(input logic [15:0] bm, input logic [3:0] fg, input logic [3:0] bg,
                       input logic inv, input logic ul, input logic bl,
                       input logic dwe, input logic dwp);
    bitmap = bm; foreground = fg; background = bg;
    invert = inv; underline = ul; blink = bl; dw_enable = dwe; dw_part = dwp;
  endtask

  // Present one word for one cycle with out_ready=1, then check it one cycle later.
  task automatic one_word(input string tag, input logic [15:0] bm, input logic inv,
                          input logic ul, input logic bl, input logic dwe, input logic dwp,
                          input logic [63:0] exp);
    @(negedge clk);
    drive(bm, 4'hA, 4'h3, inv, ul, bl, dwe, dwp);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check(tag, pixels, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  logic [15:0] bp_bm[4]  = '{16'h0001, 16'h8000, 16'h00FF, 16'hFF00};
  logic [3:0]  bp_fg[4]  = '{4'h1, 4'h5, 4'h7, 4'hC};
  logic [3:0]  bp_bg[4]  = '{4'h0, 4'h0, 4'h2, 4'h6};
  logic [63:0] bp_exp[4] = '{64'h1000_0000_0000_0000, 64'h0000_0000_0000_0005,
                             64'h7777_7777_2222_2222, 64'h6666_6666_CCCC_CCCC};

  initial begin
    int idx;
    int popped;
    reset = 1'b0; frame_tick = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(16'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_pixels", pixels, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_blink_phase", {63'd0, blink_phase}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic mapping and attributes
    one_word("basic",   16'h0001, 0, 0, 0, 0, 0, 64'hA333_3333_3333_3333);
    one_word("invert",  16'h0001, 1, 0, 0, 0, 0, 64'h3AAA_AAAA_AAAA_AAAA);
    one_word("underln", 16'h0001, 0, 1, 0, 0, 0, 64'hAAAA_AAAA_AAAA_AAAA);
    one_word("ul_inv",  16'h0001, 1, 1, 0, 0, 0, 64'h3333_3333_3333_3333);
    one_word("dw_left", 16'h0102, 0, 0, 0, 1, 0, 64'h33AA_3333_3333_3333);
    one_word("dw_right",16'h0102, 0, 0, 0, 1, 1, 64'hAA33_3333_3333_3333);
    @(negedge clk);
    check("drained", {63'd0, out_valid}, 64'd0);

    // Blink
    check("phase_0", {63'd0, blink_phase}, 64'd0);
    one_word("blink_ph0", 16'h0001, 0, 0, 1, 0, 0, 64'hA333_3333_3333_3333);
    tick();
    check("phase_1tick", {63'd0, blink_phase}, 64'd0);
    tick();
    check("phase_2tick", {63'd0, blink_phase}, 64'd1);
    one_word("blink_ph1",   16'h0001, 0, 0, 1, 0, 0, 64'h3333_3333_3333_3333);
    one_word("blink_ul",    16'h0001, 0, 1, 1, 0, 0, 64'h3333_3333_3333_3333);
    one_word("noblink_ph1", 16'h0001, 0, 0, 0, 0, 0, 64'hA333_3333_3333_3333);
    tick();
    tick();
    check("phase_4tick", {63'd0, blink_phase}, 64'd0);
    one_word("blink_ph0b", 16'h0001, 0, 0, 1, 0, 0, 64'hA333_3333_3333_3333);

    // Back-pressure with scoreboard
    idx = 0;
    popped = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      out_ready = (c >= 6);
      in_valid = (idx < 4);
      if (idx < 4) drive(bp_bm[idx], bp_fg[idx], bp_bg[idx], 0, 0, 0, 0, 0);
      #1;
      if (c == 2) check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
      if (c == 4) begin
        check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_pixels", pixels, bp_exp[0]);
      end
      if (c == 7) check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_unexpected_word", pixels, 64'd0 - 1);
        else begin
          check("bp_word", pixels, exp_q.pop_front());
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(bp_exp[idx]);
        idx++;
      end
    end
    in_valid = 1'b0;
    check("bp_popped", 64'(popped), 64'd4);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("bp_idle", {63'd0, out_valid}, 64'd0);

    // Async reset with output and skid full, blink phase 1
    tick();
    tick();
    @(negedge clk);
    out_ready = 1'b0;
    drive(16'h0001, 4'hA, 4'h3, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_skid", {63'd0, in_ready}, 64'd0);
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    check("pre_rst_phase", {63'd0, blink_phase}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_pixels", pixels, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_phase", {63'd0, blink_phase}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    check("post_rst_idle", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    drive(16'h0003, 4'h9, 4'h1, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst_pixels", pixels, 64'h9911_1111_1111_1111);
    @(negedge clk);
    check("post_rst_drain", {63'd0, out_valid}, 64'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vp_glyph_expander.md
Name: vp_glyph_expander

Overview:
- Parametrised successor of the video pipeline bitmap-to-pixel stage.
- Expands one glyph row bitmap into packed colour pixels.
- Adds configurable width and colour depth, double-width half selection, underline/blink/invert attributes and an internal blink timer.
- Uses a valid/ready handshake with a one-entry skid buffer, so the stage tolerates back-pressure from the pixel FIFO downstream.

Parameters:
- WIDTH, 16, glyph row width in pixels (even, ≥2).
- COLOR_BITS, 4, bits per pixel colour index.
- BLINK_FRAMES, 32, frame_tick pulses per blink half-period (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- frame_tick  input  1  one-cycle pulse per video frame.
- in_valid  input  1  input word valid.
- in_ready  output  1  stage can accept an input word.
- bitmap  input  WIDTH  glyph row; bit i is the i-th pixel from the left.
- foreground  input  COLOR_BITS  foreground colour index.
- background  input  COLOR_BITS  background colour index.
- invert  input  1  swap foreground and background.
- underline  input  1  force every pixel to foreground.
- blink  input  1  hide the glyph while blink_phase = 1.
- dw_enable  input  1  double-width mode.
- dw_part  input  1  double-width half select: 0 = left half of bitmap, 1 = right half.
- pixels  output  WIDTH*COLOR_BITS  packed pixels; pixel 0 occupies the MSBs.
- out_valid  output  1  pixels valid.
- out_ready  input  1  downstream accepts pixels.
- blink_phase  output  1  current blink phase.

Behaviour:
- Reset (reset = 0, asynchronous):
  - out_valid = 0, pixels = 0, skid empty, in_ready = 1.
  - blink counter = 0, blink_phase = 0.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-transfer discards both the output word and the skid word; no partial word is emitted after reset.
- Blink timer:
  - On frame_tick, counter increments.
  - When counter == BLINK_FRAMES-1 and frame_tick = 1: counter becomes 0 and blink_phase toggles.
  - BLINK_FRAMES = 1 toggles the phase on every tick.
  - blink_phase is sampled in the same cycle an input word is accepted.
- Bit transform, evaluated on the accepted word, in this order:
  - b = bitmap when dw_enable = 0.
  - When dw_enable = 1: b[i] = bitmap[dw_part*WIDTH/2 + i/2], integer division, so each source bit is duplicated.
  - underline = 1 forces b = all ones.
  - blink = 1 and blink_phase = 1 forces b = all zeros; this takes priority over underline.
  - invert = 1: colour for b[i]=1 is background, for b[i]=0 is foreground. Otherwise the mapping is straight.
  - Pixel i is placed at bits [(WIDTH-i)*COLOR_BITS-1 -: COLOR_BITS].
- Handshake:
  - Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
  - in_ready is registered: in_ready = 1 exactly when the skid is empty.
  - On accept, if the output register is empty or a transfer occurs in the same cycle, the transformed word loads the output register. Otherwise it loads the skid.
  - On transfer with the skid full, the skid moves into the output register and the skid empties.
  - Simultaneous accept and transfer with the skid empty gives output = new word, out_valid stays 1.
  - Latency: 1 cycle from accept to out_valid when not stalled.
  - Sustained throughput is 1 word/cycle while out_ready = 1.
  - pixels is held stable while out_valid = 1 and out_ready = 0.
  - No word is lost or duplicated; ordering is FIFO.
  - Input attributes are captured at accept; later input changes do not affect stored words.
  - Inputs are ignored when in_valid = 0 or in_ready = 0.

Test Plan:
- Basic mapping: WIDTH=16, COLOR_BITS=4, bitmap=16'h0001, fg=4'hA, bg=4'h3, all attributes 0, out_ready=1 -> one cycle later out_valid=1, pixels=64'hA333_3333_3333_3333.
- Invert and underline: same bitmap, invert=1 -> pixels=64'h3AAA_AAAA_AAAA_AAAA. Underline=1, invert=0 -> pixels=64'hAAAA_AAAA_AAAA_AAAA.
- Double width: bitmap=16'h0102, dw_enable=1, dw_part=0 -> pixel pattern from bits 0..7 duplicated: pixels=64'h33AA_3333_3333_3333. dw_part=1 -> pixels=64'hAA33_3333_3333_3333.
- Blink: BLINK_FRAMES=2, blink=1; words sent after 0, 2 and 4 frame_ticks -> blink_phase 0, 1, 0; the glyph is shown, then all-bg (64'h3333_3333_3333_3333), then shown.
- Back-pressure: stream 4 words with out_ready=0 -> first word held in output, second in skid, in_ready=0. Raise out_ready -> all 4 words emerge in order, none dropped or duplicated, in_ready returns to 1 one cycle after the skid drains.
- Async reset: assert reset low between clock edges with out_valid=1 and the skid full -> out_valid=0, pixels=0, in_ready=1, blink_phase=0 immediately, without waiting for an edge. After release, the first accepted word appears 1 cycle later.
